// File: rtl/data_ram.sv
// Dual-port byte-writable data RAM, single clock, registered reads.
// Define DATA_RAM_BYPASS_EN for write-first same-port reads.
module data_ram #(
   parameter int ADDR_LEN = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  wea,
   input  logic [29:0] addra,
   input  logic [31:0] dina,
   output logic [31:0] douta,
   input  logic [3:0]  web,
   input  logic [29:0] addrb,
   input  logic [31:0] dinb,
   output logic [31:0] doutb
);

   localparam int DEPTH = 1 << ADDR_LEN;

   logic [31:0] mem [DEPTH];

   logic [ADDR_LEN-1:0] idx_a;
   logic [ADDR_LEN-1:0] idx_b;
   logic [31:0]         old_a;
   logic [31:0]         old_b;
   logic [31:0]         rd_a;
   logic [31:0]         rd_b;
   logic                unused_hi;

   assign idx_a = addra[ADDR_LEN-1:0];
   assign idx_b = addrb[ADDR_LEN-1:0];
   assign unused_hi = ^{addra[29:ADDR_LEN], addrb[29:ADDR_LEN]};

   assign old_a = mem[idx_a];
   assign old_b = mem[idx_b];

`ifdef DATA_RAM_BYPASS_EN
   // Only the port's own write lanes are forwarded; the other port's
   // same-edge write stays invisible (old data).
   always_comb begin
      rd_a = old_a;
      rd_b = old_b;
      for (int i = 0; i < 4; i++) begin
         if (wea[i]) rd_a[8*i +: 8] = dina[8*i +: 8];
         if (web[i]) rd_b[8*i +: 8] = dinb[8*i +: 8];
      end
   end
`else
   assign rd_a = old_a;
   assign rd_b = old_b;
`endif

   // Port B lanes are assigned last so they win a same-word collision.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 4; i++) begin
            if (wea[i]) mem[idx_a][8*i +: 8] <= dina[8*i +: 8];
            if (web[i]) mem[idx_b][8*i +: 8] <= dinb[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         douta <= 32'h0;
         doutb <= 32'h0;
      end else begin
         douta <= rd_a;
         doutb <= rd_b;
      end
   end

endmodule

// File: tb/tb_data_ram.sv
// Directed self-checking bench for data_ram.
// Expected values are hand-computed per scenario.
module tb_data_ram;

   logic        clk;
   logic        rst_n;
   logic [3:0]  wea;
   logic [29:0] addra;
   logic [31:0] dina;
   logic [31:0] douta;
   logic [3:0]  web;
   logic [29:0] addrb;
   logic [31:0] dinb;
   logic [31:0] doutb;

   int errors;
   int checks;

   data_ram #(.ADDR_LEN(12)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wea   (wea),
      .addra (addra),
      .dina  (dina),
      .douta (douta),
      .web   (web),
      .addrb (addrb),
      .dinb  (dinb),
      .doutb (doutb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wea = 4'h0;
      web = 4'h0;
      dina = 32'h0;
      dinb = 32'h0;
   endtask

   task automatic wr_a(input logic [29:0] a, input logic [31:0] d);
      wea = 4'hF; addra = a; dina = d;
      tick();
      idle();
   endtask

   task automatic test_reset();
      checks++;
      if (douta !== 32'h0) begin
         errors++;
         $display("FAIL reset_douta actual=%h required=%h", douta, 32'h0);
      end
      checks++;
      if (doutb !== 32'h0) begin
         errors++;
         $display("FAIL reset_doutb actual=%h required=%h", doutb, 32'h0);
      end
   endtask

   task automatic test_full_write();
      wr_a(30'd5, 32'hDEADBEEF);
      addra = 30'd5;
      tick();
      checks++;
      if (douta !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL full_write actual=%h required=%h", douta, 32'hDEADBEEF);
      end
   endtask

   task automatic test_byte_lane();
      wea = 4'b0100; addra = 30'd5; dina = 32'h00AA0000;
      tick();
      idle();
      addra = 30'd5; addrb = 30'd5;
      tick();
      checks++;
      if (douta !== 32'hDEAABEEF) begin
         errors++;
         $display("FAIL byte_lane_a actual=%h required=%h", douta, 32'hDEAABEEF);
      end
      checks++;
      if (doutb !== 32'hDEAABEEF) begin
         errors++;
         $display("FAIL byte_lane_b actual=%h required=%h", doutb, 32'hDEAABEEF);
      end
      wr_a(30'd5, 32'hDEADBEEF);
   endtask

   task automatic test_collision();
      wr_a(30'd7, 32'h0);
      wea = 4'b0011; addra = 30'd7; dina = 32'h11111111;
      web = 4'b0110; addrb = 30'd7; dinb = 32'h22222222;
      tick();
      idle();
      tick();
      checks++;
      if (douta !== 32'h00222211) begin
         errors++;
         $display("FAIL collision_a actual=%h required=%h", douta, 32'h00222211);
      end
      checks++;
      if (doutb !== 32'h00222211) begin
         errors++;
         $display("FAIL collision_b actual=%h required=%h", doutb, 32'h00222211);
      end
   endtask

   task automatic test_cross_port();
      wr_a(30'd9, 32'h00000055);
      addra = 30'd9;
      web = 4'hF; addrb = 30'd9; dinb = 32'h77777777;
      tick();
      idle();
      checks++;
      if (douta !== 32'h00000055) begin
         errors++;
         $display("FAIL cross_port_old actual=%h required=%h", douta, 32'h00000055);
      end
      tick();
      checks++;
      if (douta !== 32'h77777777) begin
         errors++;
         $display("FAIL cross_port_new actual=%h required=%h", douta, 32'h77777777);
      end
   endtask

   task automatic test_read_during_write();
      logic [31:0] exp_a;
      logic [31:0] exp_b;
`ifdef DATA_RAM_BYPASS_EN
      exp_a = 32'h2;
      exp_b = 32'h112233AA;
`else
      exp_a = 32'h1;
      exp_b = 32'h11223344;
`endif
      wr_a(30'd3, 32'h1);
      wr_a(30'd4, 32'h11223344);
      wea = 4'hF; addra = 30'd3; dina = 32'h2;
      web = 4'b0001; addrb = 30'd4; dinb = 32'h000000AA;
      tick();
      idle();
      checks++;
      if (douta !== exp_a) begin
         errors++;
         $display("FAIL rdw_a actual=%h required=%h", douta, exp_a);
      end
      checks++;
      if (doutb !== exp_b) begin
         errors++;
         $display("FAIL rdw_b actual=%h required=%h", doutb, exp_b);
      end
      tick();
      checks++;
      if (douta !== 32'h2) begin
         errors++;
         $display("FAIL rdw_after actual=%h required=%h", douta, 32'h2);
      end
   endtask

   task automatic test_async_reset();
      addra = 30'd5; addrb = 30'd5;
      tick();
      checks++;
      if (douta !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL pre_reset actual=%h required=%h", douta, 32'hDEADBEEF);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (douta !== 32'h0) begin
         errors++;
         $display("FAIL async_reset_a actual=%h required=%h", douta, 32'h0);
      end
      checks++;
      if (doutb !== 32'h0) begin
         errors++;
         $display("FAIL async_reset_b actual=%h required=%h", doutb, 32'h0);
      end
      wea = 4'hF; addra = 30'd5; dina = 32'h12345678;
      web = 4'hF; addrb = 30'd5; dinb = 32'h9ABCDEF0;
      tick();
      checks++;
      if (douta !== 32'h0) begin
         errors++;
         $display("FAIL reset_hold actual=%h required=%h", douta, 32'h0);
      end
      idle();
      rst_n = 1'b1;
      tick();
      checks++;
      if (douta !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL reset_retain_a actual=%h required=%h", douta, 32'hDEADBEEF);
      end
      checks++;
      if (doutb !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL reset_retain_b actual=%h required=%h", doutb, 32'hDEADBEEF);
      end
   endtask

   task automatic test_alias();
      wr_a(30'h1005, 32'hCAFEF00D);
      addrb = 30'h0005;
      addra = 30'h2AAA5005;
      tick();
      checks++;
      if (doutb !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL alias_b actual=%h required=%h", doutb, 32'hCAFEF00D);
      end
      checks++;
      if (douta !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL alias_a actual=%h required=%h", douta, 32'hCAFEF00D);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n = 1'b0;
      addra = 30'd0;
      addrb = 30'd0;
      idle();
      tick();
      tick();
      test_reset();
      rst_n = 1'b1;
      tick();
      test_full_write();
      test_byte_lane();
      test_collision();
      test_cross_port();
      test_read_during_write();
      test_async_reset();
      test_alias();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
